// File: rtl/rng_insert_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : rng_insert_mc_if
// Brief    : Control, parameter and bitstream bundle for rng_insert_mc.
// Revision : 1.0  initial release
// ============================================================================
interface rng_insert_mc_if #(
  parameter int CH  = 4,
  parameter int WBW = 8,
  parameter int PBW = 8
) ();
  logic                iClr;
  logic                iEn;
  logic [1:0]          iMode;
  logic [WBW-1:0]      iWindow;
  logic [CH*PBW-1:0]   iProb;
  logic [CH-1:0]       iA;
  logic [CH-1:0]       oB;
  logic [CH-1:0]       oFlip;
  logic                oWinDone;

  modport master (
    output iClr, iEn, iMode, iWindow, iProb, iA,
    input  oB, oFlip, oWinDone
  );

  modport slave (
    input  iClr, iEn, iMode, iWindow, iProb, iA,
    output oB, oFlip, oWinDone
  );
endinterface
`default_nettype wire

// File: rtl/rng_insert_mc.sv
`default_nettype none
// ============================================================================
// Module   : rng_insert_mc
// Brief    : Per-channel bit insertion forcing window ones-count toward a target.
// Revision : 1.0  initial release
// ============================================================================
module rng_insert_mc #(
  parameter int CH  = 4,
  parameter int WBW = 8,
  parameter int PBW = 8
) (
  input  wire logic          iClk,
  input  wire logic          iRstN,
  rng_insert_mc_if.slave     bus
);

  localparam int          c_PW         = PBW + WBW;
  localparam logic [1:0]  c_MODE_BYP   = 2'b00;
  localparam logic [1:0]  c_MODE_EXACT = 2'b01;
  localparam logic [1:0]  c_MODE_MIN   = 2'b10;
  localparam logic [1:0]  c_MODE_MAX   = 2'b11;
  localparam logic [c_PW-1:0] c_HALF   = c_PW'(1) << (PBW - 1);

  logic [WBW-1:0]    r_pos;
  logic [WBW-1:0]    r_win;
  logic [1:0]        r_mode;
  logic [CH*PBW-1:0] r_prob;
  logic [CH-1:0]     r_b;
  logic [CH-1:0]     r_flip;
  logic              r_done;

  logic              w_start;
  logic              w_adv;
  logic [WBW-1:0]    w_win_live;
  logic [WBW-1:0]    w_win;
  logic [1:0]        w_mode;
  logic [CH*PBW-1:0] w_prob;
  logic [WBW-1:0]    w_rem;
  logic              w_last;
  logic [CH-1:0]     w_dec;

  // At window start the live parameters drive the decision and are latched.
  assign w_start    = (r_pos == '0);
  assign w_adv      = bus.iEn && !bus.iClr;
  assign w_win_live = (bus.iWindow == '0) ? WBW'(1) : bus.iWindow;
  assign w_win      = w_start ? w_win_live : r_win;
  assign w_mode     = w_start ? bus.iMode  : r_mode;
  assign w_prob     = w_start ? bus.iProb  : r_prob;
  assign w_rem      = w_win - r_pos;
  assign w_last     = (r_pos == (w_win - WBW'(1)));

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [WBW-1:0]  r_c1;
    logic [c_PW-1:0] w_prod;
    logic [WBW-1:0]  w_t;
    logic [WBW-1:0]  w_c1;
    logic [WBW-1:0]  w_need;
    logic            w_met;

    assign w_prod = c_PW'(w_prob[k*PBW +: PBW]) * c_PW'(w_win) + c_HALF;
    assign w_t    = w_prod[PBW +: WBW];
    assign w_c1   = w_start ? '0 : r_c1;
    assign w_met  = (w_c1 >= w_t);
    assign w_need = w_t - w_c1;

    always_comb begin
      w_dec[k] = bus.iA[k];
      unique case (w_mode)
        c_MODE_BYP:   w_dec[k] = bus.iA[k];
        c_MODE_EXACT: begin
          if (w_met)                 w_dec[k] = 1'b0;
          else if (w_need == w_rem)  w_dec[k] = 1'b1;
        end
        c_MODE_MIN:   if (!w_met && (w_need >= w_rem)) w_dec[k] = 1'b1;
        c_MODE_MAX:   if (w_met) w_dec[k] = 1'b0;
        default:      w_dec[k] = bus.iA[k];
      endcase
    end

    always_ff @(posedge iClk) begin
      if (!iRstN || bus.iClr) begin
        r_c1 <= '0;
      end else if (bus.iEn) begin
        r_c1 <= w_c1 + WBW'(w_dec[k]);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      r_pos  <= '0;
      r_win  <= '0;
      r_mode <= c_MODE_BYP;
      r_prob <= '0;
      r_b    <= '0;
      r_flip <= '0;
      r_done <= 1'b0;
    end else begin
      r_b    <= '0;
      r_flip <= '0;
      r_done <= 1'b0;
      if (bus.iClr) begin
        r_pos <= '0;
      end else if (w_adv) begin
        if (w_start) begin
          r_win  <= w_win_live;
          r_mode <= bus.iMode;
          r_prob <= bus.iProb;
        end
        r_pos  <= w_last ? '0 : r_pos + WBW'(1);
        r_b    <= w_dec;
        r_flip <= w_dec ^ bus.iA;
        r_done <= w_last;
      end
    end
  end

  assign bus.oB       = r_b;
  assign bus.oFlip    = r_flip;
  assign bus.oWinDone = r_done;

endmodule
`default_nettype wire

// File: doc/rng_insert_mc.md
# rng_insert_mc

Multi-channel, parametrised bit-insertion stage for stochastic bitstreams. Each channel forces 1s or 0s into its input stream so that the ones-count over a programmable window meets a per-channel target probability. Counts can be exact, at-least, or at-most per window; a registered bypass mode is also provided. It sits between SNG/RNG outputs and stochastic arithmetic, where it corrects window-level density bias.

## Interface
- CH, 4, number of independent bitstream channels
- WBW, 8, width of window length and position counters (window ≤ 2^WBW−1)
- PBW, 8, probability width; p = iProb/2^PBW, unsigned
- iClk  in  1  clock, rising edge
- iRstN  in  1  reset, synchronous, active-low
- iClr  in  1  synchronous clear of window state
- iEn  in  1  advance enable; low = stall
- iMode  in  2  00 bypass, 01 exact, 10 min, 11 max
- iWindow  in  WBW  window length W; 0 treated as 1
- iProb  in  CH*PBW  channel k target probability at bits [k*PBW +: PBW]
- iA  in  CH  input bit per channel
- oB  out  CH  output bit per channel, registered
- oFlip  out  CH  1 when oB differs from the iA it was derived from
- oWinDone  out  1  high with the last bit of each window

## Operation
- One shared position counter pos counts 0..W−1, advancing on each cycle with iEn=1 and iClr=0. It wraps to 0 after W−1.
- Window start is pos==0. On that cycle, iWindow, iMode and iProb are used live and latched into shadow registers. On all other cycles the shadow values are used. Mid-window changes have no effect until the next window.
- Per-channel target: T = (p_k*W + 2^(PBW−1)) >> PBW, with round-half-up. Full-precision product is PBW+WBW bits. T ≤ W always holds.
- Per-channel ones counter c1 counts output 1s in the current window and is forced to 0 at window start before the decision. Remaining slots R = W − pos, including the current slot. need = T − c1.
- Decision per channel, per enabled cycle:
  - bypass: oB ← iA.
  - exact: need==0 → 0; need==R → 1; else iA. This guarantees exactly T ones per window.
  - min: need≥R and need>0 → 1; else iA. At least T ones.
  - max: need==0 → 0; else iA. At most T ones.
- oFlip_k ← (decision ≠ iA_k). oWinDone ← (pos==W−1), registered together with the last bit.
- iEn=0: pos, c1 and shadows hold. oB, oFlip and oWinDone ← 0. The window resumes where it stopped.
- iClr=1 overrides iEn: pos and c1 ← 0, outputs ← 0. The next enabled cycle is a window start.

## Timing
- Latency is 1 cycle: iA sampled at edge n appears on oB after edge n.
- Reset (iRstN=0 at an edge): oB, oFlip, oWinDone, pos, c1 and shadows ← 0, with bypass selected. A reset mid-window discards the window. The first enabled cycle after reset is a window start.
- Priority, highest first: iRstN, iClr, iEn.
- W=1: every enabled cycle is both window start and oWinDone. In exact mode oB = T (0 or 1).
- T=0: exact and max modes output all 0s; min mode passes iA through. T=W: exact and min modes output all 1s.
- c1 never exceeds W; its counter width is WBW.

## Test plan
- Bypass, W=8, random iA, iEn=1 → oB = iA delayed 1 cycle, oFlip=0, oWinDone high every 8th output.
- Exact, PBW=8, W=16, p=0x40, iA all 1 → T=4. Per window: four 1s then twelve 0s; oFlip high on the last 12.
- Exact, W=16, p=0xC0, iA all 0 → T=12. Per window: four 0s then twelve 1s. Random iA over 100 windows → every window has exactly 12 ones.
- Min, W=10, p=0x80, iA all 0 → five 0s then five 1s. Max, same W and p, iA all 1 → five 1s then five 0s.
- Exact, W=16, p=0x40: change iProb to 0xFF at pos 5 → the current window still has 4 ones and the next window has 16. Drop iEn for 3 cycles at pos 8 → oB=0 during the stall, and the window still totals 4 ones with oWinDone after 16 enabled cycles.
- Assert iClr at pos 6, and separately iRstN=0 at pos 6 → outputs 0 on the next cycle. The next enabled cycle restarts pos at 0, latches fresh parameters, and the following full window meets its target.
